alu_issue_pipe: RTL
===================

ALU_ISSUE_PIPE -- requirements
Module: alu_issue_pipe

Interface
REQ-001: The block SHALL use exactly one clock and one reset: the reset is synchronous and active-high.
REQ-002: clk  input  1  rising-edge clock shared with the 4x32 register bank.
REQ-003: rst  input  1  synchronous active-high reset.
REQ-004: in_valid  input  1  an instruction is presented.
REQ-005: in_ready  output  1  the block accepts the instruction this cycle.
REQ-006: op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 MUL, 7 NOP.
REQ-007: sr1, sr2, dr  input  2 each  source and destination register indices.
REQ-008: rd_sr1, rd_sr2  output  2 each  read addresses driven to the register bank.
REQ-009: rdData1, rdData2  input  32 each  combinational read data returned by the register bank.
REQ-010: wr_en, wr_dr, wr_data  output  1/2/32  write port to the register bank; the bank captures it on the next rising edge.

Function
REQ-011: rd_sr1 and rd_sr2 SHALL equal sr1 and sr2 combinationally.
REQ-012: Accept condition: in_valid && in_ready at a rising edge.
REQ-013: On accept, the block SHALL latch op, dr and the two forwarded operands into the EX stage.
REQ-014: Operand forwarding priority, per source: (1) EX result, when EX is valid, its op is not NOP and ex_dr matches the source; (2) WB data, when wr_en is high and wr_dr matches the source; (3) rdData.
REQ-015: EX stage for single-cycle ops:
- the result is computed combinationally;
- it moves to the WB register on the next edge;
- wr_en SHALL be high for exactly one cycle, starting one cycle after the EX cycle.
- Latency: an instruction accepted at edge E0 drives wr_en during the cycle after E1, and the bank is updated at E2.
REQ-016: Arithmetic rules:
- ADD and SUB wrap modulo 2^32.
- AND, OR and XOR are bitwise.
- SLT writes 32'd1 if the operands compare signed-less-than, else 32'd0.
REQ-017: MUL SHALL produce the low 32 bits of an unsigned 32x32 product using an iterative radix-4 shift-add (2 multiplier bits per cycle).
REQ-018: MUL timing:
- MUL occupies EX for exactly 16 cycles, with a 4-bit counter running 0..15.
- On the edge ending counter value 15, the result moves to WB.
REQ-019: EX state machine:
- IDLE -> EX1 on accept of a non-MUL or NOP instruction.
- IDLE -> MULT on accept of MUL.
- EX1 -> EX1 or MULT on a back-to-back accept; EX1 -> IDLE otherwise.
- MULT -> MULT while the counter is below 15.
- MULT at count 15 -> IDLE.
REQ-020: in_ready SHALL be low while rst is high and while EX holds a MUL (all 16 cycles); it SHALL be high otherwise.
- Single-cycle ops sustain 1 instruction/cycle.
REQ-021: NOP SHALL traverse EX and WB without asserting wr_en, and SHALL never be a forwarding source.
REQ-022: Write-after-write to the same dr in consecutive instructions SHALL leave the later value in the bank.
REQ-023: When sr1 equals sr2, both operands SHALL receive the identical forwarded value.
REQ-024: in_valid is ignored while in_ready is low; the block does not capture it.

Reset
REQ-025: While rst is high at a rising edge, the block SHALL:
- clear EX valid and WB valid;
- set wr_en=0, wr_dr=2'd0 and wr_data=32'd0;
- set the MUL counter and accumulator to 0;
- set the state machine to IDLE.
REQ-026: Reset during MUL or with a pending WB SHALL abort that instruction: no wr_en ever results from it.
REQ-027: in_ready SHALL be high in the first cycle after rst deasserts.

Verification
REQ-028: Bank R0=5, then ADD dr=1, sr1=0, sr2=0 accepted at E0 -> wr_en=1, wr_dr=1, wr_data=10 during the cycle after E1, and nothing else written.
REQ-029: Back-to-back ADD R1=R0+R0 then SUB R2=R1-R0 (R0=5) -> EX forwarding yields wr_data=5 for R2. Repeat with a NOP between -> WB forwarding yields 5.
REQ-030: R3=0xFFFFFFFF, R2=3, then MUL dr=0 -> in_ready low for 16 cycles, then wr_data=0xFFFFFFFD; a dependent ADD issued immediately after forwards from WB.
REQ-031: SLT with operands 0xFFFFFFFF and 0x00000001 -> 1; operands swapped -> 0. SUB 0-1 -> 0xFFFFFFFF.
REQ-032: rst asserted on MUL cycle 8 -> no wr_en for the next 20 cycles, all outputs 0, and in_ready=1 on the first cycle after deassert.
REQ-033: A NOP stream interleaved with writes -> wr_en pulses only for non-NOP instructions, and the pulse count equals the non-NOP count.

Source files
------------

// File: rtl/alu_issue_pipe.sv
// Single-issue ALU pipe: operand forwarding, a one-cycle EX stage for simple ops,
// a 16-cycle radix-4 iterative multiplier, and a WB register that drives the
// write port of an external 4x32 register bank.
module alu_issue_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [1:0]        sr1,
  input  logic [1:0]        sr2,
  input  logic [1:0]        dr,
  output logic [1:0]        rd_sr1,
  output logic [1:0]        rd_sr2,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2,
  output logic              wr_en,
  output logic [1:0]        wr_dr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {IDLE, EX1, MULT} state_t;

  state_t                    state, state_nxt;
  logic                      accept;
  logic                      ex_fwd;
  logic signed [DATA_W-1:0]  opa, opb;
  logic signed [DATA_W-1:0]  ex_res;
  logic        [DATA_W-1:0]  acc_nxt;

  logic                      vld_p1;
  logic        [2:0]         op_p1;
  logic        [1:0]         dr_p1;
  logic signed [DATA_W-1:0]  a_p1, b_p1;
  logic        [3:0]         cnt_p1;
  logic        [DATA_W-1:0]  acc_p1;

  // Single-cycle operations; SLT compares as signed, MUL/NOP produce nothing here.
  function automatic logic signed [DATA_W-1:0] alu_fn(input logic [2:0] f,
                                                      input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    case (f)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = (a < b) ? DATA_W'(1) : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One radix-4 step: add 0/1/2/3 times the (already shifted) multiplicand.
  function automatic logic [DATA_W-1:0] mul_step(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] mcand,
                                                 input logic [1:0]        digit);
    logic [DATA_W-1:0] r;
    case (digit)
      2'd0:    r = acc;
      2'd1:    r = acc + mcand;
      2'd2:    r = acc + (mcand << 1);
      default: r = acc + mcand + (mcand << 1);
    endcase
    return r;
  endfunction

  assign rd_sr1   = sr1;
  assign rd_sr2   = sr2;
  assign in_ready = !rst && (state != MULT);
  assign accept   = in_valid && in_ready;
  assign ex_res   = alu_fn(op_p1, a_p1, b_p1);
  assign acc_nxt  = mul_step(acc_p1, $unsigned(a_p1), b_p1[1:0]);

  // Operand forwarding: live EX result first, then the pending WB write, then the bank.
  always_comb begin
    ex_fwd = (state == EX1) && vld_p1 && (op_p1 != OP_NOP);
    opa = $signed(rdData1);
    opb = $signed(rdData2);
    if (ex_fwd && (dr_p1 == sr1))      opa = ex_res;
    else if (wr_en && (wr_dr == sr1))  opa = $signed(wr_data);
    if (ex_fwd && (dr_p1 == sr2))      opb = ex_res;
    else if (wr_en && (wr_dr == sr2))  opb = $signed(wr_data);
  end

  // EX next-state: single-cycle ops stream through EX1, MUL parks in MULT for 16 cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, EX1: begin
        if (accept) state_nxt = (op == OP_MUL) ? MULT : EX1;
        else        state_nxt = IDLE;
      end
      MULT:    if (cnt_p1 == 4'd15) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // EX state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- issue -> EX (p1) control: valid and multiply step counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      cnt_p1 <= 4'd0;
      acc_p1 <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      cnt_p1 <= 4'd0;
      acc_p1 <= '0;
    end else if (state == MULT) begin
      vld_p1 <= (cnt_p1 != 4'd15);
      cnt_p1 <= cnt_p1 + 4'd1;
      acc_p1 <= acc_nxt;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  // EX data: operands captured on accept; during MUL they become shift registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1 <= op;
      dr_p1 <= dr;
      a_p1  <= opa;
      b_p1  <= opb;
    end else if (state == MULT) begin
      a_p1  <= a_p1 <<< 2;
      b_p1  <= b_p1 >> 2;
    end
  end

  // ---- EX -> WB (p2): write port, one-cycle pulse per retiring non-NOP ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_dr   <= 2'd0;
      wr_data <= '0;
    end else if ((state == EX1) && vld_p1 && (op_p1 != OP_NOP)) begin
      wr_en   <= 1'b1;
      wr_dr   <= dr_p1;
      wr_data <= ex_res;
    end else if ((state == MULT) && (cnt_p1 == 4'd15)) begin
      wr_en   <= 1'b1;
      wr_dr   <= dr_p1;
      wr_data <= acc_nxt;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule
